keypad_matrix_responder: RTL



---
 rtl/keypad_pkg.sv | 22 ++
 rtl/keypad_key_fifo.sv | 53 +++++
 rtl/keypad_matrix_responder.sv | 112 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix responder.
// A key code packs row index in [3:2] and column index in [1:0].
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam logic [3:0] ROW_IDLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [1:0] key_row(input logic [KEY_W-1:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [KEY_W-1:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Small synchronous FIFO holding queued key codes; read data is the current head.
// A push while full is dropped even when a pop happens in the same cycle.
module keypad_key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keypad_matrix_responder.sv
// Keypad-side model of a 4x4 matrix: plays back queued key presses by pulling
// the held key's row low whenever the scanner strobes that key's column.
module keypad_matrix_responder
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000,
  parameter int GAP_CYCLES  = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       col,
  output logic [3:0]       row,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             key_ready,
  output logic             busy,
  output logic             pressed,
  output logic [KEY_W-1:0] pressed_code
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int CNT_FW  = $clog2(FIFO_DEPTH) + 1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [KEY_W-1:0] cur_code, code_next;
  logic [3:0]       row_next;
  logic             busy_next;
  logic             pop;
  logic [KEY_W-1:0] fifo_head;
  logic [CNT_FW-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  keypad_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (key_valid),
    .push_data (key_code),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign key_ready = !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cur_code <= '0;
      row      <= ROW_IDLE;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      cur_code <= code_next;
      row      <= row_next;
      busy     <= busy_next;
    end
  end

  // Counters count down to zero and the state moves on at zero, never wrapping.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    code_next  = cur_code;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          code_next  = fifo_head;
          cnt_next   = CNT_W'(HOLD_CYCLES - 1);
          state_next = PRESS;
        end
      end
      PRESS: begin
        if (cnt == '0) begin
          cnt_next   = CNT_W'(GAP_CYCLES - 1);
          state_next = RELEASE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row and busy look ahead at the next state so both line up with the press window.
  always_comb begin
    row_next = ROW_IDLE;
    if (state_next == PRESS && col[key_col(code_next)] == 1'b0) begin
      row_next[key_row(code_next)] = 1'b0;
    end
    busy_next    = (state_next != IDLE) || (fifo_count != '0);
    pressed      = (state == PRESS);
    pressed_code = pressed ? cur_code : '0;
  end

endmodule
